// File: rtl/rs_issue_ctrl_if.sv
// rs_issue_ctrl_if: issue-stage valid/ready handshake and payload between the RS controller and FU select.
interface rs_issue_ctrl_if #(
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int BR_MASK_W = 4,
    parameter int FU_SEL_W  = 3
);
    logic                 iss_vld_o;
    logic                 iss_rdy_i;
    logic [PRF_IDX_W-1:0] iss_opa_tag_o;
    logic [PRF_IDX_W-1:0] iss_opb_tag_o;
    logic [PRF_IDX_W-1:0] iss_dest_tag_o;
    logic [FU_SEL_W-1:0]  iss_fu_sel_o;
    logic [31:0]          iss_IR_o;
    logic [ROB_IDX_W-1:0] iss_rob_idx_o;
    logic [BR_MASK_W-1:0] iss_br_mask_o;
    modport master (
        output iss_vld_o, iss_opa_tag_o, iss_opb_tag_o, iss_dest_tag_o,
               iss_fu_sel_o, iss_IR_o, iss_rob_idx_o, iss_br_mask_o,
        input  iss_rdy_i
    );
    modport slave (
        input  iss_vld_o, iss_opa_tag_o, iss_opb_tag_o, iss_dest_tag_o,
               iss_fu_sel_o, iss_IR_o, iss_rob_idx_o, iss_br_mask_o,
        output iss_rdy_i
    );
endinterface

// File: rtl/rs_issue_ctrl.sv
// rs_issue_ctrl: reservation-station dispatch allocation, round-robin issue select and registered issue stage
// with branch squash and br-mask correction.
module rs_issue_ctrl #(
    parameter int NUM_ENT   = 8,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int BR_MASK_W = 4,
    parameter int FU_SEL_W  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_vld_i,
    output logic                           disp_stall_o,
    input  logic [NUM_ENT-1:0]             ent_avail_i,
    input  logic [NUM_ENT-1:0]             ent_rdy_i,
    output logic [NUM_ENT-1:0]             ent_load_o,
    output logic [NUM_ENT-1:0]             ent_iss_en_o,
    input  logic [NUM_ENT*PRF_IDX_W-1:0]   ent_opa_tag_i,
    input  logic [NUM_ENT*PRF_IDX_W-1:0]   ent_opb_tag_i,
    input  logic [NUM_ENT*PRF_IDX_W-1:0]   ent_dest_tag_i,
    input  logic [NUM_ENT*FU_SEL_W-1:0]    ent_fu_sel_i,
    input  logic [NUM_ENT*32-1:0]          ent_IR_i,
    input  logic [NUM_ENT*ROB_IDX_W-1:0]   ent_rob_idx_i,
    input  logic [NUM_ENT*BR_MASK_W-1:0]   ent_br_mask_i,
    input  logic                           br_pred_correct_i,
    input  logic                           br_recovery_i,
    input  logic [BR_MASK_W-1:0]           br_tag_fix_i,
    rs_issue_ctrl_if.master                iss
);
    localparam int PTR_W = $clog2(NUM_ENT);
    localparam logic [FU_SEL_W-1:0] FU_SEL_NONE = '0;

    logic [NUM_ENT-1:0]   cand;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_vld, iss_kill, accept, issue;
    logic [BR_MASK_W-1:0] br_mask_fix;

    logic                 iss_vld_q, iss_vld_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PRF_IDX_W-1:0] opa_q, opa_d, opb_q, opb_d, dest_q, dest_d;
    logic [FU_SEL_W-1:0]  fu_sel_q, fu_sel_d;
    logic [31:0]          ir_q, ir_d;
    logic [ROB_IDX_W-1:0] rob_q, rob_d;
    logic [BR_MASK_W-1:0] br_mask_q, br_mask_d;

    assign disp_stall_o = ~|ent_avail_i;
    assign ent_load_o   = (disp_vld_i & ~rst) ? ent_avail_i & (~ent_avail_i + NUM_ENT'(1)) : '0;

    // An entry depending on a mispredicted branch is dropped from selection this cycle.
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++)
            cand[i] = ent_rdy_i[i] & ~ent_avail_i[i]
                    & ~(br_recovery_i & |(br_tag_fix_i & ent_br_mask_i[i*BR_MASK_W +: BR_MASK_W]));
    end

    // Scan downward so the candidate closest to rr_ptr wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = NUM_ENT - 1; k >= 0; k--) begin
            if (cand[rr_ptr_q + PTR_W'(k)]) begin
                grant_idx = rr_ptr_q + PTR_W'(k);
                grant_vld = 1'b1;
            end
        end
    end

    assign iss_kill     = br_recovery_i & |(br_tag_fix_i & br_mask_q) & iss_vld_q;
    assign accept       = ~iss_vld_q | iss.iss_rdy_i | iss_kill;
    assign issue        = accept & grant_vld & ~rst;
    assign ent_iss_en_o = issue ? NUM_ENT'(1) << grant_idx : '0;
    assign br_mask_fix  = br_mask_q & ~(br_pred_correct_i ? br_tag_fix_i : '0);

    always_comb begin
        rr_ptr_d  = issue ? grant_idx + PTR_W'(1) : rr_ptr_q;
        iss_vld_d = issue | (iss_vld_q & ~iss_kill & ~iss.iss_rdy_i);
        br_mask_d = issue ? ent_br_mask_i[grant_idx*BR_MASK_W +: BR_MASK_W] : br_mask_fix;
        opa_d     = issue ? ent_opa_tag_i[grant_idx*PRF_IDX_W +: PRF_IDX_W] : opa_q;
        opb_d     = issue ? ent_opb_tag_i[grant_idx*PRF_IDX_W +: PRF_IDX_W] : opb_q;
        dest_d    = issue ? ent_dest_tag_i[grant_idx*PRF_IDX_W +: PRF_IDX_W] : dest_q;
        fu_sel_d  = issue ? ent_fu_sel_i[grant_idx*FU_SEL_W +: FU_SEL_W] : fu_sel_q;
        ir_d      = issue ? ent_IR_i[grant_idx*32 +: 32] : ir_q;
        rob_d     = issue ? ent_rob_idx_i[grant_idx*ROB_IDX_W +: ROB_IDX_W] : rob_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_q <= 1'b0;
            rr_ptr_q  <= '0;
            br_mask_q <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            dest_q    <= '0;
            fu_sel_q  <= FU_SEL_NONE;
            ir_q      <= '0;
            rob_q     <= '0;
        end else begin
            iss_vld_q <= iss_vld_d;
            rr_ptr_q  <= rr_ptr_d;
            br_mask_q <= br_mask_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            dest_q    <= dest_d;
            fu_sel_q  <= fu_sel_d;
            ir_q      <= ir_d;
            rob_q     <= rob_d;
        end
    end

    assign iss.iss_vld_o      = iss_vld_q;
    assign iss.iss_opa_tag_o  = opa_q;
    assign iss.iss_opb_tag_o  = opb_q;
    assign iss.iss_dest_tag_o = dest_q;
    assign iss.iss_fu_sel_o   = fu_sel_q;
    assign iss.iss_IR_o       = ir_q;
    assign iss.iss_rob_idx_o  = rob_q;
    assign iss.iss_br_mask_o  = br_mask_fix;
endmodule
